sr_shift_ctrl: RTL and testbench

//  Sequencer for the WIDTH-bit shift-right register (serial in, parallel q).
//  - Accepts a parallel word on a valid/ready handshake.
//  - Feeds the word into the register LSB first over WIDTH enabled shift cycles.
//  - Captures the register's parallel output and presents it as rx_data with a 1-cycle rx_valid.
//  - Sits between a word-level producer/consumer and the serial shift datapath.

---
 rtl/sr_shift_ctrl.sv | 107 ++++++++++
 tb/tb_sr_shift_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sr_shift_ctrl
// Description : Word-level sequencer for a serial-in/parallel-out shift-right
//               register. Serializes a handshaked word LSB first, then captures
//               the register's parallel output as a one-cycle rx pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             abort,
    output logic             sr_en,
    output logic             sr_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic             w_capture;
    logic             w_sr_in_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // abort is deliberately ignored here: a word offered with abort is still taken
                if (tx_valid) begin
                    w_shadow_nxt = tx_data;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_IDLE;
                w_capture   = ~abort;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so sr_in lines up with the cycle sr_en is high
    assign w_sr_in_nxt = |(w_shadow_nxt & (WIDTH'(1) << w_cnt_nxt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            tx_ready <= 1'b1;
            sr_en    <= 1'b0;
            sr_in    <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            tx_ready <= (w_state_nxt == ST_IDLE);
            busy     <= (w_state_nxt != ST_IDLE);
            sr_en    <= (w_state_nxt == ST_SHIFT);
            sr_in    <= (w_state_nxt == ST_SHIFT) && w_sr_in_nxt;
            rx_valid <= w_capture;
            if (w_capture) begin
                rx_data <= sr_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_shift_ctrl.sv
`default_nettype none
// Testbench for sr_shift_ctrl: behavioural shift register plus a scoreboard
// of expected words, serial bits and rx timing.
module tb_sr_shift_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data = '0;
    logic             abort = 1'b0;
    logic             sr_en;
    logic             sr_in;
    logic [WIDTH-1:0] sr_q = '0;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rx_count = 0;
    int last_rx_cyc = 0;
    int prev_rx_cyc = 0;

    logic [WIDTH-1:0] q_word[$];
    logic             q_bit[$];
    int               q_hs[$];

    sr_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .abort    (abort),
        .sr_en    (sr_en),
        .sr_in    (sr_in),
        .sr_q     (sr_q),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Serial-in shift-right register: sr_in enters at the MSB
    always @(posedge clk) if (sr_en) sr_q <= {sr_in, sr_q[WIDTH-1:1]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            if (sr_en) begin
                if (q_bit.size() == 0) begin
                    check("sr_en_spurious", 32'(sr_en), 32'd0);
                end else begin
                    check("sr_in_bit", 32'(sr_in), 32'(q_bit.pop_front()));
                    if (q_hs.size() != 0)
                        check("sr_en_window", 32'((cyc - q_hs[0] >= 1) && (cyc - q_hs[0] <= WIDTH)), 32'd1);
                end
            end
            if (rx_valid) begin
                prev_rx_cyc = last_rx_cyc;
                last_rx_cyc = cyc;
                rx_count++;
                if (q_word.size() == 0) begin
                    check("rx_valid_spurious", 32'(rx_valid), 32'd0);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(q_word.pop_front()));
                    check("rx_latency", 32'(cyc - q_hs.pop_front()), 32'(WIDTH + 2));
                    check("rx_ready_with_valid", 32'(tx_ready), 32'd1);
                    check("bits_drained", 32'(q_bit.size()), 32'd0);
                end
            end
            if (abort && busy) begin
                q_word.delete();
                q_bit.delete();
                q_hs.delete();
            end
            if (tx_valid && tx_ready) begin
                q_word.push_back(tx_data);
                q_hs.push_back(cyc);
                for (int i = 0; i < WIDTH; i++) q_bit.push_back(tx_data[i]);
            end
        end else begin
            q_word.delete();
            q_bit.delete();
            q_hs.delete();
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return one step after the accepting edge; tx_valid stays high
    task automatic send(input logic [WIDTH-1:0] d);
        bit ok = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("tx_ready_timeout", 32'd0, 32'd1);
        next_cycle();
    endtask

    task automatic wait_rx(input int n);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (rx_count >= n) begin
                ok = 1;
                break;
            end
            next_cycle();
        end
        if (!ok) check("rx_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base;

        // 1. Reset / idle
        #12;
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_sr_en",    32'(sr_en),    32'd0);
        check("rst_sr_in",    32'(sr_in),    32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) next_cycle();
        check("idle_tx_ready", 32'(tx_ready), 32'd1);
        check("idle_sr_en",    32'(sr_en),    32'd0);
        check("idle_rx_data",  32'(rx_data),  32'd0);

        // 2. Single word
        send(4'b0001);
        tx_valid = 1'b0;
        check("shift_busy",     32'(busy),     32'd1);
        check("shift_tx_ready", 32'(tx_ready), 32'd0);
        check("shift_sr_en",    32'(sr_en),    32'd1);
        check("shift_first_bit",32'(sr_in),    32'd1);
        wait_rx(1);
        check("single_count", 32'(rx_count), 32'd1);
        next_cycle();
        check("rx_pulse_len", 32'(rx_valid), 32'd0);

        // 3. Back-to-back, with tx_data changing during the first word's shift
        base = rx_count;
        send(4'hA);
        tx_data = 4'h5;
        send(4'h5);
        tx_valid = 1'b0;
        wait_rx(base + 2);
        check("b2b_gap", 32'(last_rx_cyc - prev_rx_cyc), 32'(WIDTH + 2));
        repeat (2) next_cycle();
        check("b2b_last_data", 32'(rx_data), 32'h5);

        // 4. Abort after two shift cycles
        base = rx_count;
        send(4'hF);
        tx_valid = 1'b0;
        repeat (2) next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check("abort_sr_en",    32'(sr_en),    32'd0);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_rx_data",  32'(rx_data),  32'h5);
        repeat (8) next_cycle();
        check("abort_no_rx", 32'(rx_count - base), 32'd0);

        // abort together with tx_valid in IDLE: word still accepted
        base = rx_count;
        abort = 1'b1;
        send(4'h6);
        abort = 1'b0;
        tx_valid = 1'b0;
        wait_rx(base + 1);

        // 5. Reset in the third shift cycle
        repeat (2) next_cycle();
        send(4'h9);
        tx_valid = 1'b0;
        repeat (2) next_cycle();
        base = rx_count;
        rst = 1'b0;
        #1;
        check("arst_sr_en",    32'(sr_en),    32'd0);
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_tx_ready", 32'(tx_ready), 32'd1);
        check("arst_rx_valid", 32'(rx_valid), 32'd0);
        check("arst_rx_data",  32'(rx_data),  32'd0);
        @(negedge clk);
        next_cycle();
        rst = 1'b1;
        repeat (6) next_cycle();
        check("arst_no_rx", 32'(rx_count - base), 32'd0);
        send(4'h3);
        tx_valid = 1'b0;
        wait_rx(base + 1);
        next_cycle();
        check("post_rst_data", 32'(rx_data), 32'h3);

        // 6. tx_data scrambled during SHIFT must not affect the latched word
        base = rx_count;
        send(4'hC);
        tx_valid = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tx_data = 4'(i * 5 + 3);
            next_cycle();
        end
        wait_rx(base + 1);

        // A few random words through the scoreboard
        for (int i = 0; i < 6; i++) begin
            base = rx_count;
            send(4'($urandom_range(0, 15)));
            tx_valid = 1'b0;
            wait_rx(base + 1);
        end

        repeat (3) next_cycle();
        check("sb_empty", 32'(q_word.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
